// File: rtl/spike_frame_sequencer.sv
// rtl/spike_frame_sequencer.sv - double-buffered temporal-code frame sequencer with result FIFO
module spike_frame_sequencer #(
    parameter int NUM_SPIKES  = 64,
    parameter int TIME_PERIOD = 8,
    parameter int TW          = $clog2(TIME_PERIOD) + 1,
    parameter int NUM_NEURONS = 16,
    parameter int NW          = $clog2(NUM_NEURONS) + 1,
    parameter int RES_DEPTH   = 4,
    parameter int EMIT_TRAIN  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SPIKES*TW-1:0] in_spike_times,
    input  logic                     in_training,
    output logic [TW-1:0]            time_val,
    output logic [NUM_SPIKES*TW-1:0] spike_times,
    output logic [NUM_SPIKES-1:0]    spike_pulse,
    output logic                     training,
    output logic                     frame_start,
    output logic                     busy,
    input  logic [NW-1:0]            layer_winner,
    input  logic [TW-1:0]            layer_out_time,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [NW-1:0]            res_winner,
    output logic [TW-1:0]            res_out_time,
    output logic                     res_no_spike
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int EW = NW + TW + 1;
    localparam logic [TW-1:0] LAST_T = TW'(TIME_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE} state_t;

    state_t                  state, state_nxt;
    logic                    pend_full, pend_full_nxt;
    logic [NUM_SPIKES*TW-1:0] pend_times;
    logic                    pend_training;

    logic [EW-1:0]           fifo_mem [RES_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             count_after;
    logic [EW-1:0]           head;

    logic accept, push, wr_en, pop, space_ok, promote;

    assign accept   = in_valid && in_ready;
    assign res_valid = (fifo_count != '0);
    assign pop      = res_valid && res_ready;
    assign push     = (state == S_CAPTURE) && (!training || (EMIT_TRAIN != 0));
    assign wr_en    = push && ((fifo_count != CW'(RES_DEPTH)) || pop);

    // Occupancy as it will stand after this edge; the next frame reserves its slot up front
    assign count_after = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space_ok    = (pend_training && (EMIT_TRAIN == 0)) || (count_after < (CW+1)'(RES_DEPTH));
    assign promote     = pend_full && space_ok && ((state == S_IDLE) || (state == S_CAPTURE));
    assign pend_full_nxt = accept ? 1'b1 : (promote ? 1'b0 : pend_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (promote) state_nxt = S_RUN;
            S_RUN:     if (time_val == LAST_T) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = promote ? S_RUN : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full     <= 1'b0;
            pend_times    <= '0;
            pend_training <= 1'b0;
            in_ready      <= 1'b0;
        end else begin
            pend_full <= pend_full_nxt;
            in_ready  <= !pend_full_nxt;
            if (accept) begin
                pend_times    <= in_spike_times;
                pend_training <= in_training;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_times <= '0;
            training    <= 1'b0;
            time_val    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= promote;
            if (promote) begin
                spike_times <= pend_times;
                training    <= pend_training;
                time_val    <= '0;
            end else if (state == S_RUN) begin
                time_val <= (time_val == LAST_T) ? '0 : time_val + 1'b1;
            end
        end
    end

    always_comb begin
        spike_pulse = '0;
        for (int i = 0; i < NUM_SPIKES; i++) begin
            spike_pulse[i] = (state == S_RUN) && (spike_times[i*TW +: TW] == time_val);
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {layer_winner, layer_out_time,
                                 (layer_out_time >= TW'(TIME_PERIOD))};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)   rd_ptr <= (rd_ptr == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head fields read as zero while empty so nothing stale is visible after reset
    assign head         = fifo_mem[rd_ptr];
    assign res_winner   = res_valid ? head[EW-1 -: NW] : '0;
    assign res_out_time = res_valid ? head[TW:1] : '0;
    assign res_no_spike = res_valid ? head[0] : 1'b0;

endmodule
